// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back hazard unit.
package wb_pkg;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam int unsigned CW = 16;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic          valid;
        logic          we;
        logic          load;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } slot_t;

    // A slot produces register r when it will really write it; R0 never counts.
    function automatic logic slot_live(input slot_t s, input logic [AW-1:0] r);
        return s.valid & s.we & (s.rd == r) & (r != '0);
    endfunction

endpackage

// File: rtl/wb_hazard_unit_if.sv
// Decode/datapath <-> hazard unit signal bundle, including the register-file write port.
interface wb_hazard_unit_if #(
    parameter int unsigned DW = wb_pkg::DW,
    parameter int unsigned AW = wb_pkg::AW
);
    logic          issue_valid;
    logic          issue_we;
    logic          issue_load;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] issue_ra;
    logic [AW-1:0] issue_rb;
    logic          use_ra;
    logic          use_rb;
    logic          flush;
    logic [DW-1:0] ex_result;
    logic [DW-1:0] mem_rdata;

    logic          stall;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [DW-1:0] fwd_ex;
    logic [DW-1:0] fwd_mem;
    logic [DW-1:0] fwd_wb;
    logic          rf_we;
    logic [AW-1:0] rf_rw;
    logic [DW-1:0] rf_busw;
    logic [15:0]   wb_count;

    modport master (
        output issue_valid, issue_we, issue_load, issue_rd, issue_ra, issue_rb,
        output use_ra, use_rb, flush, ex_result, mem_rdata,
        input  stall, fwd_a, fwd_b, fwd_ex, fwd_mem, fwd_wb,
        input  rf_we, rf_rw, rf_busw, wb_count
    );

    modport slave (
        input  issue_valid, issue_we, issue_load, issue_rd, issue_ra, issue_rb,
        input  use_ra, use_rb, flush, ex_result, mem_rdata,
        output stall, fwd_a, fwd_b, fwd_ex, fwd_mem, fwd_wb,
        output rf_we, rf_rw, rf_busw, wb_count
    );

endinterface

// File: rtl/wb_hazard_unit_fwd_select.sv
// Youngest-first operand forwarding select for one source register.
module fwd_select
    import wb_pkg::*;
(
    input  logic [AW-1:0] i_src,
    input  logic          i_use,
    input  slot_t         i_ex,
    input  slot_t         i_mem,
    input  slot_t         i_wb,
    output logic [1:0]    o_sel
);

    // Only the tags matter here; the data fields are carried for a uniform slot view.
    logic w_unused_data;
    assign w_unused_data = ^{i_ex.data, i_mem.data, i_wb.data};

    // A load in EX has no result yet, so it falls through to older slots.
    always_comb begin
        o_sel = FWD_RF;
        if (i_use) begin
            if (slot_live(i_ex, i_src) && !i_ex.load) begin
                o_sel = FWD_EX;
            end else if (slot_live(i_mem, i_src)) begin
                o_sel = FWD_MEM;
            end else if (slot_live(i_wb, i_src)) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/wb_hazard_unit.sv
// EX/MEM/WB destination tracker: forwarding selects, load-use stall and the
// single write port of the 8x16 register file.
module wb_hazard_unit
    import wb_pkg::*;
#(
    parameter int unsigned DW = wb_pkg::DW,
    parameter int unsigned AW = wb_pkg::AW
) (
    input logic           clk,
    input logic           reset,
    wb_hazard_unit_if.slave bus
);

    slot_t           r_ex;
    slot_t           r_mem;
    slot_t           r_wb;
    logic [CW-1:0]   r_wb_count;

    logic            w_hit_a;
    logic            w_hit_b;
    logic            w_stall;
    logic            w_accept;
    logic            w_rf_we;
    logic [DW-1:0]   w_mem_data;
    logic [DW-1:0]   w_wb_data;
    logic [AW-1:0]   w_wb_rd;

    // Load-use: the load's data only exists once it reaches MEM.
    assign w_hit_a  = bus.use_ra & r_ex.load & slot_live(r_ex, bus.issue_ra);
    assign w_hit_b  = bus.use_rb & r_ex.load & slot_live(r_ex, bus.issue_rb);
    assign w_stall  = bus.issue_valid & (w_hit_a | w_hit_b);
    assign w_accept = bus.issue_valid & ~w_stall & ~bus.flush;

    assign w_mem_data = r_mem.load ? bus.mem_rdata : DW'(r_mem.data);
    assign w_wb_data  = DW'(r_wb.data);
    assign w_wb_rd    = AW'(r_wb.rd);
    assign w_rf_we    = r_wb.valid & r_wb.we & (r_wb.rd != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex       <= '0;
            r_mem      <= '0;
            r_wb       <= '0;
            r_wb_count <= '0;
        end else begin
            r_wb <= '{valid: r_mem.valid, we: r_mem.we, load: r_mem.load,
                      rd: r_mem.rd, data: w_mem_data};

            // A taken branch kills the EX occupant before it can advance.
            if (bus.flush) begin
                r_mem <= '0;
            end else begin
                r_mem <= '{valid: r_ex.valid, we: r_ex.we, load: r_ex.load,
                           rd: r_ex.rd, data: bus.ex_result};
            end

            if (w_accept) begin
                r_ex <= '{valid: 1'b1, we: bus.issue_we, load: bus.issue_load,
                          rd: bus.issue_rd, data: '0};
            end else begin
                r_ex <= '0;
            end

            if (w_rf_we) begin
                r_wb_count <= r_wb_count + CW'(1);
            end
        end
    end

    fwd_select u_fwd_a (
        .i_src (bus.issue_ra),
        .i_use (bus.use_ra),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .i_wb  (r_wb),
        .o_sel (bus.fwd_a)
    );

    fwd_select u_fwd_b (
        .i_src (bus.issue_rb),
        .i_use (bus.use_rb),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .i_wb  (r_wb),
        .o_sel (bus.fwd_b)
    );

    assign bus.stall    = w_stall;
    assign bus.fwd_ex   = bus.ex_result;
    assign bus.fwd_mem  = w_mem_data;
    assign bus.fwd_wb   = w_wb_data;
    assign bus.rf_we    = w_rf_we;
    assign bus.rf_rw    = w_wb_rd;
    assign bus.rf_busw  = w_wb_data;
    assign bus.wb_count = r_wb_count;

endmodule

// File: tb/tb_wb_hazard_unit.sv
// Directed bench for wb_hazard_unit with a cycle-history reference model.
module tb_wb_hazard_unit;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    wb_hazard_unit_if bus ();

    wb_hazard_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model history: what decode presented in each cycle and what was accepted.
    bit          h_acc [8];
    bit          h_we  [8];
    bit          h_ld  [8];
    bit          h_fl  [8];
    logic [2:0]  h_rd  [8];
    logic [15:0] h_exr [8];
    logic [15:0] h_mrd [8];
    int          cyc      = 0;
    int          last_rst = -1;
    bit          seen_rst = 1'b0;
    logic [15:0] m_count  = 16'h0;

    function automatic bit ok_at(input int k);
        return (k >= 0) && (k > last_rst) && h_acc[k % 8];
    endfunction

    function automatic bit live(input bit v, input int k, input logic [2:0] r);
        return v && h_we[k % 8] && (h_rd[k % 8] == r) && (r != 3'd0);
    endfunction

    function automatic logic [1:0] fsel(input logic [2:0] src, input bit u,
                                        input bit ev, input int ke,
                                        input bit mv, input int km,
                                        input bit wv, input int kw);
        if (!u) return 2'd0;
        if (live(ev, ke, src) && !h_ld[ke % 8]) return 2'd1;
        if (live(mv, km, src)) return 2'd2;
        if (live(wv, kw, src)) return 2'd3;
        return 2'd0;
    endfunction

    always @(negedge clk) begin : cmp
        int          ke, km, kw, idx;
        bit          ev, mv, wv, st_e, we_e;
        logic [15:0] md, wd;
        ke = cyc - 1;
        km = cyc - 2;
        kw = cyc - 3;
        ev = ok_at(ke);
        mv = ok_at(km) && !h_fl[(km + 1) % 8];
        wv = ok_at(kw) && !h_fl[(kw + 1) % 8];
        st_e = bus.issue_valid && ev && h_we[ke % 8] && h_ld[ke % 8] && (h_rd[ke % 8] != 3'd0) &&
               ((bus.use_ra && (bus.issue_ra == h_rd[ke % 8])) ||
                (bus.use_rb && (bus.issue_rb == h_rd[ke % 8])));
        we_e = wv && h_we[kw % 8] && (h_rd[kw % 8] != 3'd0);
        md = 16'h0;
        wd = 16'h0;
        if (mv) md = h_ld[km % 8] ? bus.mem_rdata : h_exr[(km + 1) % 8];
        if (wv) wd = h_ld[kw % 8] ? h_mrd[(kw + 2) % 8] : h_exr[(kw + 1) % 8];

        if (seen_rst) begin
            chk("m_stall", 32'(bus.stall), 32'(st_e));
            chk("m_fwd_a", 32'(bus.fwd_a), 32'(fsel(bus.issue_ra, bus.use_ra, ev, ke, mv, km, wv, kw)));
            chk("m_fwd_b", 32'(bus.fwd_b), 32'(fsel(bus.issue_rb, bus.use_rb, ev, ke, mv, km, wv, kw)));
            chk("m_fwd_ex", 32'(bus.fwd_ex), 32'(bus.ex_result));
            chk("m_rf_we", 32'(bus.rf_we), 32'(we_e));
            chk("m_wb_count", 32'(bus.wb_count), 32'(m_count));
            if (we_e) begin
                chk("m_rf_rw", 32'(bus.rf_rw), 32'(h_rd[kw % 8]));
                chk("m_rf_busw", 32'(bus.rf_busw), 32'(wd));
            end
            if (mv) chk("m_fwd_mem", 32'(bus.fwd_mem), 32'(md));
            if (wv) chk("m_fwd_wb", 32'(bus.fwd_wb), 32'(wd));
        end

        idx = cyc % 8;
        h_acc[idx] = bus.issue_valid && !st_e && !bus.flush && !reset;
        h_we[idx]  = bus.issue_we;
        h_ld[idx]  = bus.issue_load;
        h_rd[idx]  = bus.issue_rd;
        h_exr[idx] = bus.ex_result;
        h_mrd[idx] = bus.mem_rdata;
        h_fl[idx]  = bus.flush;
        m_count    = reset ? 16'h0 : (m_count + 16'(we_e));
        if (reset) begin
            last_rst = cyc;
            seen_rst = 1'b1;
        end
        cyc++;
    end

    task automatic drv(input bit v, input bit we, input bit ld, input int rd,
                       input int ra, input int rb, input bit ua, input bit ub,
                       input bit fl, input logic [15:0] exr, input logic [15:0] mrd);
        @(posedge clk);
        #1;
        reset           = 1'b0;
        bus.issue_valid = v;
        bus.issue_we    = we;
        bus.issue_load  = ld;
        bus.issue_rd    = 3'(rd);
        bus.issue_ra    = 3'(ra);
        bus.issue_rb    = 3'(rb);
        bus.use_ra      = ua;
        bus.use_rb      = ub;
        bus.flush       = fl;
        bus.ex_result   = exr;
        bus.mem_rdata   = mrd;
    endtask

    task automatic nop(input logic [15:0] exr = 16'h0, input logic [15:0] mrd = 16'h0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, exr, mrd);
    endtask

    task automatic rst_cycle();
        nop();
        reset = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rf_we"},    32'(bus.rf_we),    32'h0);
        chk({tag, "_rf_rw"},    32'(bus.rf_rw),    32'h0);
        chk({tag, "_rf_busw"},  32'(bus.rf_busw),  32'h0);
        chk({tag, "_wb_count"}, 32'(bus.wb_count), 32'h0);
        chk({tag, "_stall"},    32'(bus.stall),    32'h0);
        chk({tag, "_fwd_a"},    32'(bus.fwd_a),    32'h0);
        chk({tag, "_fwd_b"},    32'(bus.fwd_b),    32'h0);
    endtask

    initial begin
        reset = 1'b1;
        bus.issue_valid = 1'b0; bus.issue_we = 1'b0; bus.issue_load = 1'b0;
        bus.issue_rd = 3'd0; bus.issue_ra = 3'd0; bus.issue_rb = 3'd0;
        bus.use_ra = 1'b0; bus.use_rb = 1'b0; bus.flush = 1'b0;
        bus.ex_result = 16'h0; bus.mem_rdata = 16'h0;
        repeat (3) @(posedge clk);

        nop(); #2 chk_reset_state("rst");

        // ALU write to R3 lands exactly three cycles after issue.
        drv(1, 1, 0, 3, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        nop(16'h1234);
        nop(); #2 chk("s1_early_we", 32'(bus.rf_we), 32'h0);
        nop(); #2;
        chk("s1_rf_we", 32'(bus.rf_we), 32'h1);
        chk("s1_rf_rw", 32'(bus.rf_rw), 32'h3);
        chk("s1_rf_busw", 32'(bus.rf_busw), 32'h1234);
        nop(); #2 chk("s1_count", 32'(bus.wb_count), 32'h1);

        // Back-to-back ALU dependence: EX then MEM forwarding, no stall.
        drv(1, 1, 0, 4, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        drv(1, 0, 0, 1, 4, 0, 1, 0, 0, 16'h4444, 16'h0); #2;
        chk("s2_fwd_a_ex", 32'(bus.fwd_a), 32'h1);
        chk("s2_stall", 32'(bus.stall), 32'h0);
        drv(1, 0, 0, 1, 4, 0, 1, 0, 0, 16'h0, 16'h0); #2;
        chk("s2_fwd_a_mem", 32'(bus.fwd_a), 32'h2);
        nop(); nop(); nop();

        // Load-use: one stall, then MEM forwarding of the load data.
        drv(1, 1, 1, 5, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        drv(1, 0, 0, 0, 0, 5, 0, 1, 0, 16'h0, 16'h0); #2;
        chk("s3_stall", 32'(bus.stall), 32'h1);
        drv(1, 0, 0, 0, 0, 5, 0, 1, 0, 16'h0, 16'h00AB); #2;
        chk("s3_stall_clr", 32'(bus.stall), 32'h0);
        chk("s3_fwd_b", 32'(bus.fwd_b), 32'h2);
        chk("s3_fwd_mem", 32'(bus.fwd_mem), 32'h00AB);
        nop(); nop(); nop();

        // Writes to R0 never reach the file; R0 is never forwarded.
        drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 16'hBEEF, 16'h0); #2;
        chk("s4_fwd_a", 32'(bus.fwd_a), 32'h0);
        nop(); nop(); #2 chk("s4_rf_we", 32'(bus.rf_we), 32'h0);
        nop(); #2 chk("s4_count", 32'(bus.wb_count), 32'h3);

        // Flush kills the EX load to R6 while a dependent issue is stalled.
        drv(1, 1, 1, 6, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        drv(1, 1, 0, 7, 6, 0, 1, 0, 1, 16'h0, 16'h0); #2;
        chk("s5_stall", 32'(bus.stall), 32'h1);
        drv(1, 1, 0, 7, 6, 0, 1, 0, 0, 16'h0, 16'h0); #2;
        chk("s5_restall", 32'(bus.stall), 32'h0);
        chk("s5_fwd_a", 32'(bus.fwd_a), 32'h0);
        nop(16'h0777); #2 chk("s5_no_r6", 32'(bus.rf_we), 32'h0);
        nop(); #2 chk("s5_gap", 32'(bus.rf_we), 32'h0);
        nop(); #2;
        chk("s5_rf_we", 32'(bus.rf_we), 32'h1);
        chk("s5_rf_rw", 32'(bus.rf_rw), 32'h7);
        chk("s5_rf_busw", 32'(bus.rf_busw), 32'h0777);
        nop(); #2 chk("s5_count", 32'(bus.wb_count), 32'h4);

        // Counter wrap: fill to 0xFFFF, then one more write.
        for (int i = 0; i < 65531; i++) begin
            drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 16'(i), 16'h0);
        end
        nop(); nop(); nop(); nop(); #2;
        chk("s6_count_max", 32'(bus.wb_count), 32'hFFFF);
        drv(1, 1, 0, 2, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        nop(16'h5A5A); nop(); nop(); nop(); #2;
        chk("s6_count_wrap", 32'(bus.wb_count), 32'h0);

        // Reset with two writes in flight discards both.
        drv(1, 1, 0, 2, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        drv(1, 1, 0, 3, 0, 0, 0, 0, 0, 16'h2222, 16'h0);
        rst_cycle();
        nop(); #2 chk_reset_state("rst2");
        for (int i = 0; i < 3; i++) begin
            nop(); #2 chk("rst2_no_we", 32'(bus.rf_we), 32'h0);
        end
        nop(); #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_hazard_unit.md
# wb_hazard_unit

Writer-side companion to the processor's 8×16-bit register file. Tracks in-flight destination registers across the EX, MEM and WB pipeline slots and drives the file's write port (RW, enableWrite, BusW). Produces operand-forwarding selects and a load-use stall for decode. Sits between decode/execute/memory and the register file; it is the sole writer of that file.

## Interface
Parameters:
- `DW`, 16: datapath width.
- `AW`, 3: register index width; R0 is hard-wired zero.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `issue_valid` in 1: decode presents an instruction this cycle.
- `issue_we` in 1: instruction writes a register.
- `issue_load` in 1: instruction is a load; result arrives in MEM.
- `issue_rd` in AW: destination index.
- `issue_ra`, `issue_rb` in AW: source indices.
- `use_ra`, `use_rb` in 1: the corresponding source is actually read.
- `flush` in 1: kill the instruction currently in EX (branch taken).
- `ex_result` in DW: ALU result of the EX-slot instruction, valid during EX.
- `mem_rdata` in DW: load data of the MEM-slot instruction, valid during MEM.
- `stall` out 1: decode must hold; issue not accepted.
- `fwd_a`, `fwd_b` out 2: operand source. 0 = register file, 1 = EX, 2 = MEM, 3 = WB.
- `fwd_ex`, `fwd_mem`, `fwd_wb` out DW: forwarding data buses.
- `rf_we` out 1: to register file `enableWrite`.
- `rf_rw` out AW: to `RW`.
- `rf_busw` out DW: to `BusW`.
- `wb_count` out 16: number of committed register writes.

## Operation
- Three slot registers: EX, MEM and WB. Each holds `valid`, `we`, `load`, `rd` and `data`. EX holds no data; MEM and WB hold `data`.
- Each posedge, when not in reset:
  - WB ← MEM, with `data = MEM.load ? mem_rdata : MEM.data`.
  - MEM ← EX, with `data = ex_result`.
  - EX ← the issued instruction if `issue_valid & ~stall & ~flush`; otherwise a bubble (`valid = 0`).
- `flush` bubbles EX before it advances: MEM receives a bubble, and the issued instruction is also dropped.
- A slot is live for rd `r` when `valid & we & (rd == r) & (r != 0)`.
- `fwd_a` priority, youngest first:
  - EX live for `issue_ra`, not a load → 1.
  - else MEM live → 2.
  - else WB live → 3.
  - else 0.
  - `fwd_b` uses the same rule with `issue_rb`.
- When `use_ra` is 0, `fwd_a` = 0; likewise `use_rb` gates `fwd_b`.
- Forwarding buses:
  - `fwd_ex = ex_result`.
  - `fwd_mem = MEM.load ? mem_rdata : MEM.data`.
  - `fwd_wb = WB.data`.
- `stall` is asserted (combinational) when `issue_valid` and EX is a live load whose rd matches a used source.
  - A stall inserts exactly one bubble; the load then sits in MEM and forwards through select 2.
- `flush` and `stall` in the same cycle: EX receives a bubble. `stall` still reads high that cycle; decode re-presents the instruction next cycle.
- Write port: `rf_we = WB.valid & WB.we & (WB.rd != 0)`, `rf_rw = WB.rd`, `rf_busw = WB.data`.
  - Writes to R0 are never asserted.
- `wb_count` increments on each posedge where `rf_we` = 1 and wraps from 0xFFFF to 0x0000.

## Timing
- Reset (synchronous): all slot `valid` = 0 and all slot data = 0. This gives `rf_we` = 0, `rf_rw` = 0, `rf_busw` = 0x0000, `wb_count` = 0, `stall` = 0, `fwd_a` = `fwd_b` = 0.
- Reset mid-operation discards all in-flight writes; nothing reaches the register file after the reset edge.
- Issue-to-write latency: an instruction accepted at edge N occupies EX in cycle N+1, MEM in N+2 and WB in N+3.
  - `rf_we` is high during cycle N+3.
  - The register file commits on the falling edge within that cycle.
- `stall`, `fwd_*` and the `rf_*` outputs are combinational from slot state and inputs; there is no output register.
- A back-to-back dependent ALU op has zero stall cycles. A load followed by its consumer has one stall cycle.

## Structure
- Shared package `wb_pkg`:
  - Constants `FWD_RF` = 0, `FWD_EX` = 1, `FWD_MEM` = 2, `FWD_WB` = 3.
  - Slot struct typedef (`valid`, `we`, `load`, `rd`, `data`).
  - `DW` and `AW` defaults.
- One sub-module, `fwd_select`: priority mux from one source index plus the three slots to a 2-bit select. It is instantiated twice, for A and B.

## Test plan
- Reset, then issue `rd=3`, ALU, `ex_result=0x1234` → `rf_we=1`, `rf_rw=3`, `rf_busw=0x1234` exactly 3 cycles after issue; `wb_count=1`.
- ALU `rd=4`, then next cycle an op with `ra=4` → `fwd_a=1`, `stall=0`; an op two cycles later with `ra=4` → `fwd_a=2`.
- Load `rd=5`, then consumer with `rb=5` → `stall=1` for one cycle; after the re-issue `fwd_b=2` and `fwd_mem` equals `mem_rdata=0x00AB`.
- Issue with `rd=0`, `we=1` → `rf_we` never asserts, `wb_count` unchanged; a consumer with `ra=0` → `fwd_a=0`.
- `flush` while EX holds a write to R6 → no `rf_we` for R6 three cycles later; a stalled issue in the same cycle is re-accepted next cycle.
- Preload `wb_count` to 0xFFFF via 65535 writes, one more write → 0x0000. Assert `reset` while two writes are in flight → no subsequent `rf_we`, and all outputs return to their reset values.
